pipe_ctrl: RTL and testbench

- Centralised, parametrised stall/flush/redirect controller for the in-order RV64 pipeline.
- Replaces the per-stage BR_STALL/TRAP_STALL wiring and the ad-hoc flush OR in the top level.
- Synchronises the external interrupt (UART) and drains the pipeline before vectoring to mtvec.
- Issues a single registered PC-load/flush command to fetch and the stage registers.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/irq_sync.sv | 29 ++
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush/redirect controller.
// Stage indices assume the default five-stage layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_REDIR = 2'd2
  } ctrl_state_e;

  localparam int STG_DE  = 0;
  localparam int STG_EXE = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/irq_sync.sv
// Synchroniser for the asynchronous interrupt level.
// Produces a one-cycle pulse on each synchronised rising edge.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller: drains the pipe before taking an
// interrupt and issues one registered PC-load/flush command per decision.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int                NUM_STAGES  = 5,
  parameter int                XLEN        = 64,
  parameter int                SYNC_STAGES = 2,
  parameter logic [XLEN-1:0]   RESET_PC    = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  irq_in,
  input  logic                  irq_en,
  input  logic [NUM_STAGES-1:0] stage_valid,
  input  logic [NUM_STAGES-1:0] br_pend,
  input  logic [NUM_STAGES-1:0] trap_pend,
  input  logic                  dep_stall,
  input  logic                  wb_retire,
  input  logic [XLEN-1:0]       wb_npc,
  input  logic                  redir_valid,
  input  logic                  redir_is_trap,
  input  logic [XLEN-1:0]       redir_target,
  input  logic [XLEN-1:0]       trap_vec,
  output logic                  fe_stall,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic                  pc_load,
  output logic [XLEN-1:0]       pc_target,
  output logic                  irq_take,
  output logic [XLEN-1:0]       irq_epc,
  output logic [1:0]            ctrl_state
);

  localparam logic [NUM_STAGES-1:0] FLUSH_FRONT = {1'b0, {(NUM_STAGES-1){1'b1}}};

  ctrl_state_e           state_q, state_d;
  logic                  irq_pend_q, irq_pend_d;
  logic                  redir_trap_q, redir_trap_d;
  logic [XLEN-1:0]       last_npc_q, last_npc_d;
  logic                  pc_load_q, pc_load_d;
  logic [XLEN-1:0]       pc_target_q, pc_target_d;
  logic [NUM_STAGES-1:0] flush_q, flush_d;
  logic                  irq_take_q, irq_take_d;
  logic [XLEN-1:0]       irq_epc_q, irq_epc_d;
  logic                  irq_rise;
  logic                  pend_clr;
  logic [XLEN-1:0]       redir_pc;
  logic                  unused_stage_valid;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk     (CLK),
    .rst_n   (RESET),
    .async_i (irq_in),
    .rise_o  (irq_rise)
  );

  // Decode's own valid bit is irrelevant: decode is killed while draining.
  assign unused_stage_valid = stage_valid[STG_DE];

  assign redir_pc   = redir_is_trap ? trap_vec : redir_target;
  assign last_npc_d = redir_valid ? redir_pc : (wb_retire ? wb_npc : last_npc_q);
  assign irq_pend_d = irq_rise | (irq_pend_q & ~pend_clr);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    redir_trap_d = redir_trap_q;
    pc_load_d    = 1'b0;
    pc_target_d  = '0;
    flush_d      = '0;
    irq_take_d   = 1'b0;
    irq_epc_d    = irq_epc_q;
    pend_clr     = 1'b0;
    fe_stall     = 1'b1;

    case (state_q)
      CTRL_RUN: begin
        fe_stall = (|br_pend) | (|trap_pend) | dep_stall;
        if (redir_valid) begin
          pc_load_d   = 1'b1;
          pc_target_d = redir_pc;
          flush_d     = FLUSH_FRONT;
        end else if (irq_pend_q && irq_en) begin
          state_d = CTRL_DRAIN;
        end
      end
      CTRL_DRAIN: begin
        flush_d[STG_DE] = 1'b1;
        if (redir_valid && redir_is_trap) begin
          state_d      = CTRL_REDIR;
          redir_trap_d = 1'b1;
          flush_d      = FLUSH_FRONT;
        end else if (redir_valid) begin
          flush_d = FLUSH_FRONT;
        end else if (!irq_en) begin
          // Interrupt withdrawn: refetch the instruction killed in decode.
          state_d     = CTRL_RUN;
          pc_load_d   = 1'b1;
          pc_target_d = last_npc_q;
        end else if (stage_valid[NUM_STAGES-1:1] == '0) begin
          state_d      = CTRL_REDIR;
          redir_trap_d = 1'b0;
        end
      end
      CTRL_REDIR: begin
        state_d         = CTRL_RUN;
        pc_load_d       = 1'b1;
        pc_target_d     = trap_vec;
        flush_d[STG_DE] = 1'b1;
        if (!redir_trap_q) begin
          irq_take_d = 1'b1;
          irq_epc_d  = last_npc_q;
          pend_clr   = 1'b1;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= CTRL_RUN;
      irq_pend_q   <= 1'b0;
      redir_trap_q <= 1'b0;
      last_npc_q   <= RESET_PC;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
      flush_q      <= '0;
      irq_take_q   <= 1'b0;
      irq_epc_q    <= '0;
    end else begin
      state_q      <= state_d;
      irq_pend_q   <= irq_pend_d;
      redir_trap_q <= redir_trap_d;
      last_npc_q   <= last_npc_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
      flush_q      <= flush_d;
      irq_take_q   <= irq_take_d;
      irq_epc_q    <= irq_epc_d;
    end
  end

  assign stage_flush = flush_q;
  assign pc_load     = pc_load_q;
  assign pc_target   = pc_target_q;
  assign irq_take    = irq_take_q;
  assign irq_epc     = irq_epc_q;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int NS = 5;
  localparam int XL = 64;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          irq_in, irq_en, dep_stall, wb_retire;
  logic          redir_valid, redir_is_trap;
  logic [NS-1:0] stage_valid, br_pend, trap_pend;
  logic [XL-1:0] wb_npc, redir_target, trap_vec;
  logic          fe_stall, pc_load, irq_take;
  logic [NS-1:0] stage_flush;
  logic [XL-1:0] pc_target, irq_epc;
  logic [1:0]    ctrl_state;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.NUM_STAGES(NS), .XLEN(XL), .SYNC_STAGES(2), .RESET_PC('0)) dut (
    .CLK(CLK), .RESET(RESET), .irq_in(irq_in), .irq_en(irq_en),
    .stage_valid(stage_valid), .br_pend(br_pend), .trap_pend(trap_pend),
    .dep_stall(dep_stall), .wb_retire(wb_retire), .wb_npc(wb_npc),
    .redir_valid(redir_valid), .redir_is_trap(redir_is_trap),
    .redir_target(redir_target), .trap_vec(trap_vec),
    .fe_stall(fe_stall), .stage_flush(stage_flush), .pc_load(pc_load),
    .pc_target(pc_target), .irq_take(irq_take), .irq_epc(irq_epc),
    .ctrl_state(ctrl_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cycles, output int n);
    n = 0;
    while (ctrl_state != s && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pc_load"},  pc_load, 1'b0);
    check({tag, "_irq_take"}, irq_take, 1'b0);
    check({tag, "_flush"},    stage_flush, 5'b00000);
  endtask

  logic [NS-1:0] drain_sv  [4] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000};
  logic [XL-1:0] drain_npc [4] = '{64'h1ff8, 64'h1ffc, 64'h2000, 64'h2004};

  initial begin
    int n;
    RESET = 1'b0; irq_in = 0; irq_en = 0; dep_stall = 0; wb_retire = 0;
    redir_valid = 0; redir_is_trap = 0; stage_valid = '0; br_pend = '0;
    trap_pend = '0; wb_npc = '0; redir_target = '0; trap_vec = '0;
    tick(); tick();
    check("rst_state", ctrl_state, 2'd0);
    check("rst_pc_target", pc_target, 64'h0);
    RESET = 1'b1;
    tick();
    check("idle_state", ctrl_state, 2'd0);
    check("idle_fe_stall", fe_stall, 1'b0);
    check("idle_epc", irq_epc, 64'h0);
    check_idle("idle");

    // Branch pending in stage 2 stalls fetch combinationally.
    br_pend = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      #1 check("br_fe_stall", fe_stall, 1'b1);
      tick();
      check("br_pc_load", pc_load, 1'b0);
    end
    br_pend = '0;
    #1 check("br_release", fe_stall, 1'b0);
    dep_stall = 1'b1;
    #1 check("dep_fe_stall", fe_stall, 1'b1);
    dep_stall = 1'b0;

    // Non-trap redirect in RUN.
    redir_valid = 1; redir_target = 64'h1000; redir_is_trap = 0;
    tick();
    redir_valid = 0;
    check("redir_pc_load", pc_load, 1'b1);
    check("redir_target", pc_target, 64'h1000);
    check("redir_flush", stage_flush, 5'b01111);
    check("redir_state", ctrl_state, 2'd0);
    tick();
    check_idle("redir_after");
    check("redir_after_target", pc_target, 64'h0);

    // Trap redirect in RUN goes straight to the trap vector.
    trap_vec = 64'h8000; redir_valid = 1; redir_is_trap = 1; redir_target = 64'h1234;
    tick();
    redir_valid = 0; redir_is_trap = 0;
    check("rtrap_target", pc_target, 64'h8000);
    check("rtrap_irq_take", irq_take, 1'b0);

    // Interrupt with a four-cycle drain.
    irq_en = 1; stage_valid = 5'b11110; irq_in = 1;
    wait_state(2'd1, 10, n);
    check("irq_latency", n, 4);
    for (int i = 0; i < 4; i++) begin
      stage_valid = drain_sv[i]; wb_retire = 1; wb_npc = drain_npc[i];
      #1 check("drain_fe_stall", fe_stall, 1'b1);
      tick();
      check("drain_state", ctrl_state, 2'd1);
      check("drain_flush0", stage_flush, 5'b00001);
      check("drain_no_load", pc_load, 1'b0);
    end
    stage_valid = '0; wb_retire = 0;
    tick();
    check("to_redir", ctrl_state, 2'd2);
    check("redir_fe_stall", fe_stall, 1'b1);
    tick();
    check("irq_pc_load", pc_load, 1'b1);
    check("irq_target", pc_target, 64'h8000);
    check("irq_take", irq_take, 1'b1);
    check("irq_epc", irq_epc, 64'h2004);
    check("irq_state_run", ctrl_state, 2'd0);
    tick();
    check_idle("irq_after");
    check("irq_epc_hold", irq_epc, 64'h2004);
    tick();
    check("irq_pend_cleared", ctrl_state, 2'd0);

    // Second interrupt interrupted by a trap redirect while draining.
    irq_in = 0;
    tick(); tick(); tick();
    irq_in = 1; stage_valid = 5'b00010;
    wait_state(2'd1, 10, n);
    check("irq2_latency", n, 4);
    trap_vec = 64'h9000; redir_valid = 1; redir_is_trap = 1;
    tick();
    redir_valid = 0; redir_is_trap = 0;
    check("dtrap_state", ctrl_state, 2'd2);
    check("dtrap_flush", stage_flush, 5'b01111);
    tick();
    check("dtrap_pc_load", pc_load, 1'b1);
    check("dtrap_target", pc_target, 64'h9000);
    check("dtrap_irq_take", irq_take, 1'b0);
    check("dtrap_epc_hold", irq_epc, 64'h2004);
    check("dtrap_state_run", ctrl_state, 2'd0);
    tick();
    check("dtrap_redrain", ctrl_state, 2'd1);

    // Non-trap redirect while draining: flush only, stay in DRAIN.
    redir_valid = 1; redir_target = 64'h3000;
    tick();
    redir_valid = 0;
    check("dbr_state", ctrl_state, 2'd1);
    check("dbr_flush", stage_flush, 5'b01111);
    check("dbr_no_load", pc_load, 1'b0);

    // Interrupt enable withdrawn mid-drain: refetch from last NPC.
    wb_retire = 1; wb_npc = 64'h3008;
    tick();
    wb_retire = 0; irq_en = 0;
    tick();
    check("den_state", ctrl_state, 2'd0);
    check("den_pc_load", pc_load, 1'b1);
    check("den_target", pc_target, 64'h3008);
    check("den_irq_take", irq_take, 1'b0);
    tick();
    check("den_after_load", pc_load, 1'b0);
    check("den_stay_run", ctrl_state, 2'd0);

    // Re-enable (interrupt still pending), then reset in the middle of DRAIN.
    irq_en = 1;
    tick();
    check("rst_mid_drain_pre", ctrl_state, 2'd1);
    RESET = 1'b0;
    #1;
    check("rst_mid_state", ctrl_state, 2'd0);
    check("rst_mid_pc_load", pc_load, 1'b0);
    check("rst_mid_epc", irq_epc, 64'h0);
    tick();
    check("rst_mid_no_load", pc_load, 1'b0);
    RESET = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
